// File: rtl/fpu8_op_if.sv
// Bundle between the FPU op sequencer and its requester, exception screen and datapath.
// slave = sequencer view, master = surrounding logic view.
interface fpu8_op_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [1:0]  chk_op;
  logic [7:0]  chk_a;
  logic [7:0]  chk_b;
  logic        exc_caught;
  logic [2:0]  exc_code;
  logic        dp_start;
  logic [1:0]  dp_op;
  logic [7:0]  dp_a;
  logic [7:0]  dp_b;
  logic        dp_done;
  logic [7:0]  dp_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_exc;
  logic [2:0]  rsp_exc_code;
  logic        sticky_clr;
  logic [7:0]  sticky_exc;
  logic [15:0] op_count;

  modport slave (
    input  req_valid, req_op, req_a, req_b, exc_caught, exc_code,
           dp_done, dp_result, rsp_ready, sticky_clr,
    output req_ready, chk_op, chk_a, chk_b, dp_start, dp_op, dp_a, dp_b,
           rsp_valid, rsp_result, rsp_exc, rsp_exc_code, sticky_exc, op_count
  );

  modport master (
    output req_valid, req_op, req_a, req_b, exc_caught, exc_code,
           dp_done, dp_result, rsp_ready, sticky_clr,
    input  req_ready, chk_op, chk_a, chk_b, dp_start, dp_op, dp_a, dp_b,
           rsp_valid, rsp_result, rsp_exc, rsp_exc_code, sticky_exc, op_count
  );
endinterface

// File: rtl/fpu8_op_controller.sv
// Single-issue sequencer for the 8-bit FPU: screens operands, issues to the datapath,
// returns result or exception, keeps sticky exception flags and a completion count.
//
// state | meaning
// IDLE  | ready for a request, operands latched on req_valid
// CHECK | exception module evaluates chk_*, exceptional ops short-circuit to RESP
// ISSUE | dp_start pulse, watchdog loaded
// WAIT  | waiting for dp_done or watchdog expiry
// RESP  | first cycle loads rsp_valid, then held until rsp_ready
module fpu8_op_controller #(
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [7:0]  NAN_RESULT   = 8'h7F,
  parameter logic [2:0]  TIMEOUT_CODE = 3'b111
) (
  input logic      clk,
  input logic      rst_n,
  fpu8_op_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [7:0]  tmr;
  logic [1:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        valid_q;
  logic [7:0]  result_q;
  logic        exc_q;
  logic [2:0]  code_q;
  logic [7:0]  sticky_q;
  logic [15:0] cnt_ops;
  logic        hs;
  logic [7:0]  sticky_set;

  assign hs         = (state == S_RESP) && valid_q && bus.rsp_ready;
  assign sticky_set = (hs && exc_q) ? (8'd1 << code_q) : 8'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tmr      <= 8'd0;
      op_q     <= 2'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      valid_q  <= 1'b0;
      result_q <= 8'd0;
      exc_q    <= 1'b0;
      code_q   <= 3'd0;
      sticky_q <= 8'd0;
      cnt_ops  <= 16'd0;
    end else begin
      // a flag set on the same edge as a clear survives the clear
      sticky_q <= (bus.sticky_clr ? 8'd0 : sticky_q) | sticky_set;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q  <= bus.req_op;
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (bus.exc_caught) begin
            result_q <= NAN_RESULT;
            exc_q    <= 1'b1;
            code_q   <= bus.exc_code;
            state    <= S_RESP;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr   <= TMR_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.dp_done) begin
            result_q <= bus.dp_result;
            exc_q    <= 1'b0;
            code_q   <= 3'd0;
            state    <= S_RESP;
          end else if (tmr == 8'd0) begin
            result_q <= NAN_RESULT;
            exc_q    <= 1'b1;
            code_q   <= TIMEOUT_CODE;
            state    <= S_RESP;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_RESP: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            cnt_ops <= cnt_ops + 16'd1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.chk_op       = op_q;
  assign bus.chk_a        = a_q;
  assign bus.chk_b        = b_q;
  assign bus.dp_start     = (state == S_ISSUE);
  assign bus.dp_op        = op_q;
  assign bus.dp_a         = a_q;
  assign bus.dp_b         = b_q;
  assign bus.rsp_valid    = valid_q;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_exc      = exc_q;
  assign bus.rsp_exc_code = code_q;
  assign bus.sticky_exc   = sticky_q;
  assign bus.op_count     = cnt_ops;
endmodule

// File: tb/tb_fpu8_op_controller.sv
// Directed bench for fpu8_op_controller: vector table for single operations plus
// hand-written sequences for backpressure, sticky clear, counter wrap and reset mid-op.
module tb_fpu8_op_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu8_op_if ifc ();
  fpu8_op_controller #(.TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       exc;
    logic [2:0] code;
    int         dly;
    logic [7:0] res;
    logic [7:0] exp_res;
    logic       exp_exc;
    logic [2:0] exp_code;
    int         exp_lat;
    int         exp_starts;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  exp_sticky = 8'd0;
  logic [15:0] exp_count  = 16'd0;

  int dp_delay = 0;
  int dp_cnt = 0;
  int dp_starts = 0;
  logic [7:0] dp_res_cfg = 8'd0;
  logic [1:0] seen_op = 2'd0;
  logic [7:0] seen_a = 8'd0;
  logic [7:0] seen_b = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // datapath model: dp_done pulses dp_delay cycles after the dp_start cycle (0 = never)
  initial begin
    ifc.dp_done = 1'b0;
    ifc.dp_result = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      ifc.dp_done = 1'b0;
      if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          ifc.dp_done = 1'b1;
          ifc.dp_result = dp_res_cfg;
        end
      end
      @(negedge clk);
      if (ifc.dp_start) begin
        dp_starts++;
        dp_cnt = dp_delay;
        seen_op = ifc.dp_op;
        seen_a = ifc.dp_a;
        seen_b = ifc.dp_b;
      end
    end
  end

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (ifc.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int lat;
    int s0;
    ifc.exc_caught = v.exc;
    ifc.exc_code = v.code;
    dp_delay = v.dly;
    dp_res_cfg = v.res;
    s0 = dp_starts;
    ifc.req_valid = 1'b1;
    ifc.req_op = v.op;
    ifc.req_a = v.a;
    ifc.req_b = v.b;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    wait_rsp(lat);
    check({tag, "_lat"}, lat, v.exp_lat);
    check({tag, "_result"}, ifc.rsp_result, v.exp_res);
    check({tag, "_exc"}, ifc.rsp_exc, v.exp_exc);
    check({tag, "_code"}, ifc.rsp_exc_code, v.exp_code);
    check({tag, "_starts"}, dp_starts - s0, v.exp_starts);
    if (v.exp_starts == 1) begin
      check({tag, "_dp_op"}, seen_op, v.op);
      check({tag, "_dp_a"}, seen_a, v.a);
      check({tag, "_dp_b"}, seen_b, v.b);
    end
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.rsp_ready = 1'b0;
    ifc.exc_caught = 1'b0;
    exp_count = exp_count + 16'd1;
    if (v.exp_exc) exp_sticky = exp_sticky | (8'd1 << v.exp_code);
    check({tag, "_valid_drop"}, ifc.rsp_valid, 1'b0);
    check({tag, "_ready"}, ifc.req_ready, 1'b1);
    check({tag, "_count"}, ifc.op_count, exp_count);
    check({tag, "_sticky"}, ifc.sticky_exc, exp_sticky);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t w;
    int lat;
    int bad;
    logic [7:0] held;
    // op a b exc code dly res | exp_res exp_exc exp_code lat starts
    vecs[0] = '{2'd0, 8'h38, 8'h38, 1'b0, 3'd0, 3, 8'h40, 8'h40, 1'b0, 3'd0, 6, 1};
    vecs[1] = '{2'd3, 8'hFF, 8'h10, 1'b1, 3'd1, 1, 8'h00, 8'h7F, 1'b1, 3'd1, 2, 0};
    vecs[2] = '{2'd2, 8'h21, 8'h43, 1'b0, 3'd0, 1, 8'h55, 8'h55, 1'b0, 3'd0, 4, 1};
    vecs[3] = '{2'd1, 8'h0A, 8'h0B, 1'b0, 3'd0, 0, 8'h00, 8'h7F, 1'b1, 3'd7, 7, 1};
    vecs[4] = '{2'd0, 8'h30, 8'h31, 1'b0, 3'd0, 4, 8'h3C, 8'h3C, 1'b0, 3'd0, 7, 1};
    vecs[5] = '{2'd1, 8'h44, 8'h45, 1'b0, 3'd0, 5, 8'h11, 8'h7F, 1'b1, 3'd7, 7, 1};
    vecs[6] = '{2'd2, 8'h80, 8'hFE, 1'b1, 3'd5, 1, 8'h00, 8'h7F, 1'b1, 3'd5, 2, 0};

    ifc.req_valid = 1'b0;
    ifc.req_op = 2'd0;
    ifc.req_a = 8'd0;
    ifc.req_b = 8'd0;
    ifc.exc_caught = 1'b0;
    ifc.exc_code = 3'd0;
    ifc.rsp_ready = 1'b0;
    ifc.sticky_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", ifc.req_ready, 1'b1);
    check("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    check("rst_dp_start", ifc.dp_start, 1'b0);
    check("rst_chk_a", ifc.chk_a, 8'd0);
    check("rst_rsp_result", ifc.rsp_result, 8'd0);
    check("rst_sticky", ifc.sticky_exc, 8'd0);
    check("rst_count", ifc.op_count, 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // backpressure, then a blocked second request that is an exception with code 2
    dp_delay = 1;
    dp_res_cfg = 8'h5A;
    ifc.req_valid = 1'b1;
    ifc.req_op = 2'd0;
    ifc.req_a = 8'h12;
    ifc.req_b = 8'h34;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    wait_rsp(lat);
    check("bp_lat", lat, 4);
    held = ifc.rsp_result;
    check("bp_result", held, 8'h5A);
    ifc.exc_caught = 1'b1;
    ifc.exc_code = 3'd2;
    ifc.req_valid = 1'b1;
    ifc.req_op = 2'd3;
    ifc.req_a = 8'hEE;
    ifc.req_b = 8'h01;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (!ifc.rsp_valid || ifc.rsp_result !== 8'h5A || ifc.req_ready || ifc.chk_a !== 8'h12) bad++;
    end
    check("bp_stall_cycles_bad", bad, 0);
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("bp_not_accepted_chk_a", ifc.chk_a, 8'h12);
    check("bp_ready_after_hs", ifc.req_ready, 1'b1);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    check("bp_second_accepted", ifc.chk_a, 8'hEE);
    check("bp_second_busy", ifc.req_ready, 1'b0);
    wait_rsp(lat);
    check("clr_lat", lat, 2);
    check("clr_code", ifc.rsp_exc_code, 3'd2);
    ifc.sticky_clr = 1'b1;
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.sticky_clr = 1'b0;
    ifc.rsp_ready = 1'b0;
    ifc.exc_caught = 1'b0;
    exp_count = exp_count + 16'd1;
    exp_sticky = 8'h04;
    check("clr_sticky", ifc.sticky_exc, exp_sticky);
    check("clr_count", ifc.op_count, exp_count);

    // counter wrap
    force dut.cnt_ops = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.cnt_ops;
    exp_count = 16'hFFFF;
    check("wrap_preload", ifc.op_count, 16'hFFFF);
    w = vecs[1];
    do_op(w, "wrap");
    check("wrap_zero", ifc.op_count, 16'd0);

    // reset while waiting on the datapath; late dp_done must be ignored
    dp_delay = 3;
    dp_res_cfg = 8'h66;
    lat = dp_starts;
    ifc.req_valid = 1'b1;
    ifc.req_op = 2'd0;
    ifc.req_a = 8'h77;
    ifc.req_b = 8'h78;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    bad = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (dp_starts != lat) begin
        bad = 0;
        break;
      end
    end
    check("rstop_start_seen", bad, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 16'd0;
    exp_sticky = 8'd0;
    check("rstop_req_ready", ifc.req_ready, 1'b1);
    check("rstop_rsp_valid", ifc.rsp_valid, 1'b0);
    check("rstop_chk_a", ifc.chk_a, 8'd0);
    check("rstop_dp_a", ifc.dp_a, 8'd0);
    check("rstop_rsp_result", ifc.rsp_result, 8'd0);
    check("rstop_rsp_exc", ifc.rsp_exc, 1'b0);
    check("rstop_sticky", ifc.sticky_exc, exp_sticky);
    check("rstop_count", ifc.op_count, exp_count);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (ifc.rsp_valid || !ifc.req_ready || ifc.dp_start) bad++;
    end
    check("rstop_late_done_bad", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpu8_op_controller.md
Name: fpu8_op_controller

Overview:
- Single-issue sequencer for the 8-bit FPU: accepts one operation request at a time, screens operands through the existing exception module, and issues non-exceptional operations to the arithmetic datapath.
- Returns the result or exception response to the requester.
- Keeps sticky per-code exception flags and a completed-operation counter.
- Sits between the requesting logic (core/bus adapter) and the FPU datapath plus exception module.

Parameters:
- TIMEOUT, 64, max cycles in WAIT without dp_done before forced abort (legal range 2..255)
- NAN_RESULT, 8'h7F, result byte returned with any exception response
- TIMEOUT_CODE, 3'b111, exception code reported on timeout abort

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request
- req_op  in  2  0=add, 1=sub, 2=mul, 3=div
- req_a  in  8  operand A
- req_b  in  8  operand B
- chk_op  out  2  registered op driven to exception module
- chk_a  out  8  registered operand A to exception module
- chk_b  out  8  registered operand B to exception module
- exc_caught  in  1  exception module flag (combinational from chk_*)
- exc_code  in  3  exception module code
- dp_start  out  1  one-cycle datapath start pulse
- dp_op  out  2  op to datapath (= chk_op)
- dp_a  out  8  operand A to datapath (= chk_a)
- dp_b  out  8  operand B to datapath (= chk_b)
- dp_done  in  1  datapath result valid, one-cycle pulse
- dp_result  in  8  datapath result
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_result  out  8  result byte
- rsp_exc  out  1  response is an exception
- rsp_exc_code  out  3  exception code (0 when rsp_exc=0)
- sticky_clr  in  1  clear all sticky flags
- sticky_exc  out  8  bit k set once any response with rsp_exc=1 and code k
- op_count  out  16  responses handed off, wraps at 16'hFFFF->0

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready=1. This includes chk_*, dp_*, rsp_*, sticky_exc and op_count.
  - Reset overrides any in-flight operation. A late dp_done arriving after reset is ignored.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/a/b into chk_* and go to CHECK.
  - req_ready=0 in every other state; one operation in flight.
- CHECK (1 cycle):
  - Sample exc_caught/exc_code.
  - If exc_caught=1: load rsp_result=NAN_RESULT, rsp_exc=1, rsp_exc_code=exc_code, and go to RESP. The datapath is never started.
  - Else go to ISSUE.
- ISSUE (1 cycle):
  - dp_start=1 for exactly this cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - On dp_done: rsp_result=dp_result, rsp_exc=0, rsp_exc_code=0, go to RESP.
  - Else increment the timeout counter.
  - When the counter reaches TIMEOUT: rsp_result=NAN_RESULT, rsp_exc=1, rsp_exc_code=TIMEOUT_CODE, go to RESP.
  - dp_done on the same cycle as the timeout threshold: dp_done wins.
  - dp_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1, with rsp_* held stable until rsp_ready=1.
  - On handshake:
    - rsp_valid drops next cycle and state returns to IDLE.
    - op_count increments.
    - If rsp_exc=1, sticky_exc[rsp_exc_code] is set.
- Latencies:
  - Exception path: request accepted at edge N, rsp_valid=1 after edge N+2.
  - Normal path with dp_done at earliest (the cycle after dp_start): rsp_valid after edge N+4.
  - Back-to-back: a new request is accepted no earlier than the cycle after a response handshake.
- sticky_clr:
  - Clears all bits on the next edge.
  - If a sticky set and sticky_clr happen on the same edge, the set bit ends at 1 and all other bits are cleared.
- dp_op/dp_a/dp_b are stable from ISSUE through WAIT. chk_* are held from CHECK until the next accepted request.

Test Plan:
- Normal add:
  - Stimulus: req op=0, a=8'h38, b=8'h38, exc_caught=0; datapath model asserts dp_done 3 cycles after dp_start with dp_result=8'h40.
  - Required: exactly one dp_start pulse; rsp_valid with rsp_result=8'h40, rsp_exc=0, code=0; op_count=1; sticky_exc=0.
- Exception short-circuit:
  - Stimulus: req op=3, a=NaN pattern; exception model drives exc_caught=1, exc_code=3'b001.
  - Required: dp_start never asserts; rsp_valid 2 cycles after acceptance with rsp_result=8'h7F, rsp_exc=1, code=3'b001; after handshake sticky_exc=8'h02.
- Timeout:
  - Stimulus: TIMEOUT=4, no dp_done.
  - Required: response with rsp_exc=1, code=3'b111, result 8'h7F; sticky_exc[7]=1.
  - Stimulus: separate run with dp_done on the threshold cycle.
  - Required: normal result.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles; pulse req_valid meanwhile.
  - Required: rsp_* stable; req_ready=0; second request not accepted until after the handshake.
- Sticky/counter edges:
  - Stimulus: sticky_clr on the same edge as an exception handshake with code 2.
  - Required: sticky_exc=8'h04.
  - Stimulus: op_count preloaded via 65535 handshakes (or forced), then one more handshake.
  - Required: op_count wraps to 0.
- Reset mid-operation:
  - Stimulus: drop rst_n for one cycle during WAIT; then dp_done arrives.
  - Required: all outputs zero and req_ready=1; late dp_done produces no response.
